// File: rtl/carry_save_accumulator.sv
// Carry-save accumulator: folds a group of operands into sum/carry vectors
// and presents them to a downstream carry-propagate adder.
module carry_save_accumulator #(
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_sum,
   output logic [ADDR_WIDTH-1:0] out_carry,
   output logic [CNT_WIDTH-1:0]  out_count,
   output logic                  out_sat
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] s;
   logic [ADDR_WIDTH-1:0] c;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  sat;
   logic                  vld;

   logic                  accept;
   logic                  cnt_max;
   logic [ADDR_WIDTH-1:0] s_nxt;
   logic [ADDR_WIDTH-1:0] maj;
   logic [ADDR_WIDTH-1:0] c_nxt;

   assign in_ready = !rst && (state != HOLD);
   assign accept   = in_valid && in_ready;
   assign cnt_max  = &cnt;

   // 3:2 compression; the carry leaving the MSB is dropped (modulo wrap)
   assign s_nxt = s ^ c ^ in_data;
   assign maj   = (s & c) | (s & in_data) | (c & in_data);
   assign c_nxt = {maj[ADDR_WIDTH-2:0], 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s     <= '0;
         c     <= '0;
         cnt   <= '0;
         sat   <= 1'b0;
         vld   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  s   <= s_nxt;
                  c   <= c_nxt;
                  cnt <= cnt_max ? cnt : cnt + CNT_WIDTH'(1);
                  if (cnt_max)
                     sat <= 1'b1;
                  state <= in_last ? HOLD : ACCUM;
                  vld   <= in_last;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= IDLE;
                  s     <= '0;
                  c     <= '0;
                  cnt   <= '0;
                  sat   <= 1'b0;
                  vld   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               vld   <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = vld;
   assign out_sum   = s;
   assign out_carry = c;
   assign out_count = cnt;
   assign out_sat   = sat;

endmodule

// File: doc/carry_save_accumulator.md
CARRY_SAVE_ACCUMULATOR -- requirements
Module: carry_save_accumulator

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, giving the operand and result vector width in bits.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the operand-count width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  ADDR_WIDTH  unsigned operand, modulo 2^ADDR_WIDTH.
REQ-008 in_last  input  1  marks the final operand of a group.
REQ-009 out_valid  output  1  result vectors valid; held until accepted.
REQ-010 out_ready  input  1  downstream carry-propagate adder consumes the result.
REQ-011 out_sum  output  ADDR_WIDTH  carry-save sum vector.
REQ-012 out_carry  output  ADDR_WIDTH  carry-save carry vector, already shifted left one bit.
REQ-013 out_count  output  CNT_WIDTH  number of operands in the group, saturating.
REQ-014 out_sat  output  1  out_count has saturated.

Function
REQ-015 States SHALL be IDLE (accumulator empty), ACCUM (at least one non-last operand taken) and HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD and 0 while rst is high.
REQ-017 An operand SHALL be accepted only on a cycle where in_valid and in_ready are both 1; any other cycle leaves all state unchanged.
REQ-018 On accept, with S, C the current vectors and D = in_data: S' = S xor C xor D, C' = ((S&C)|(S&D)|(C&D)) shifted left 1, bit 0 = 0, bit shifted out of the MSB discarded.
REQ-019 The invariant (S + C) mod 2^ADDR_WIDTH = (sum of accepted operands) mod 2^ADDR_WIDTH SHALL hold after every accept.
REQ-020 The count SHALL increment by 1 per accept, stick at 2^CNT_WIDTH-1, and out_sat SHALL be set on any accept made with the count already at its maximum.
REQ-021 Accept with in_last=0: IDLE->ACCUM, ACCUM->ACCUM.
REQ-022 Accept with in_last=1 (from IDLE or ACCUM): next state HOLD, out_valid=1 from the next cycle, with out_sum/out_carry/out_count/out_sat reflecting that operand included.
REQ-023 Latency SHALL be one cycle from the accept of the last operand to out_valid=1.
REQ-024 In HOLD, out_sum, out_carry, out_count and out_sat SHALL stay stable while out_ready=0; in_valid SHALL be ignored.
REQ-025 In HOLD with out_ready=1: next cycle out_valid=0, S=C=0, count=0, out_sat=0, state IDLE; the freed cycle is a one-cycle bubble.
REQ-026 out_valid SHALL be 0 in IDLE and ACCUM; out_ready SHALL be ignored outside HOLD.
REQ-027 A single-operand group (in_last=1 from IDLE) SHALL yield out_sum = D, out_carry = 0, out_count = 1.
REQ-028 No arithmetic overflow flag is provided; wrap modulo 2^ADDR_WIDTH is the defined behaviour.

Reset
REQ-029 While rst=1 at a clock edge: state IDLE, S=C=0, count=0, out_valid=0, out_sat=0, out_sum=0, out_carry=0, out_count=0.
REQ-030 rst SHALL take priority over any accept or out handshake in the same cycle, including mid-group and in HOLD; the partial group is discarded.
REQ-031 in_ready SHALL be 1 on the first cycle after rst deasserts.

Verification (ADDR_WIDTH=16, CNT_WIDTH=8 unless stated)
REQ-032 Reset: hold rst 2 cycles -> all outputs 0; in_ready=1 on first cycle after release.
REQ-033 Operands 3, 5, 6(last), out_ready=1 -> out_sum=0x0002, out_carry=0x000C, out_count=3, out_sat=0; sum=14.
REQ-034 Wrap: 0xFFFF, 0x0001(last) -> out_sum=0xFFFE, out_carry=0x0002, (out_sum+out_carry) mod 2^16=0.
REQ-035 Backpressure: group 9(last), out_ready=0 for 5 cycles with in_valid=1 -> outputs stable at 9/0/1, in_ready=0, no operand consumed; out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-036 Reset mid-group: accept 4, 4, assert rst 1 cycle, then 7(last) -> out_sum=7, out_carry=0, out_count=1.
REQ-037 Saturation (CNT_WIDTH=4): twenty operands of 1 with in_valid gaps, last on 20th -> out_count=15, out_sat=1, out_sum+out_carry=20.
